// File: rtl/clock_pkg.sv
// Shared encodings for the time-setting editor: edit states, digit positions
// and the BCD limits used when stepping a digit.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    EDIT_TIME  = 2'd1,
    EDIT_ALARM = 2'd2
  } edit_state_t;

  localparam logic [2:0] IDX_HOUR_SHI = 3'd5;
  localparam logic [2:0] IDX_HOUR_GE  = 3'd4;
  localparam logic [2:0] IDX_MIN_SHI  = 3'd3;
  localparam logic [2:0] IDX_MIN_GE   = 3'd2;
  localparam logic [2:0] IDX_SEC_SHI  = 3'd1;
  localparam logic [2:0] IDX_SEC_GE   = 3'd0;

  localparam logic [3:0] LIM_UNITS      = 4'd9;
  localparam logic [3:0] LIM_TENS       = 4'd5;
  localparam logic [3:0] LIM_HOUR_SHI   = 4'd2;
  localparam logic [3:0] LIM_HOUR_GE_HI = 4'd3;

  // The hour units digit only reaches 3 once the hour tens digit is 2.
  function automatic logic [3:0] digit_limit(input logic [2:0] idx,
                                             input logic [3:0] hour_shi);
    logic [3:0] lim;
    lim = LIM_UNITS;
    case (idx)
      IDX_HOUR_SHI:            lim = LIM_HOUR_SHI;
      IDX_HOUR_GE:             lim = (hour_shi == LIM_HOUR_SHI) ? LIM_HOUR_GE_HI : LIM_UNITS;
      IDX_MIN_SHI, IDX_SEC_SHI: lim = LIM_TENS;
      default:                 lim = LIM_UNITS;
    endcase
    return lim;
  endfunction

  function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] lim);
    return (d >= lim) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/time_setter_if.sv
// Link between the button editor and the time-keeping core: the core's live
// time in, the edited time and the alarm settings out.
interface time_setter_if;
  logic [3:0] cur_sec_ge, cur_sec_shi, cur_min_ge, cur_min_shi, cur_hour_ge, cur_hour_shi;
  logic       set_time_finish;
  logic [3:0] set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi;
  logic       clock_en;
  logic [3:0] clock_min_ge, clock_min_shi, clock_hour_ge, clock_hour_shi;

  modport master (
    input  cur_sec_ge, cur_sec_shi, cur_min_ge, cur_min_shi, cur_hour_ge, cur_hour_shi,
    output set_time_finish,
    output set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi,
    output clock_en, clock_min_ge, clock_min_shi, clock_hour_ge, clock_hour_shi
  );

  modport slave (
    output cur_sec_ge, cur_sec_shi, cur_min_ge, cur_min_shi, cur_hour_ge, cur_hour_shi,
    input  set_time_finish,
    input  set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi,
    input  clock_en, clock_min_ge, clock_min_shi, clock_hour_ge, clock_hour_shi
  );
endinterface

// File: rtl/key_debounce.sv
// Push-button filter: a new level is accepted after DEBOUNCE_CYCLES equal
// samples, and an accepted rising level produces a one-cycle press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          stable;
  logic [CW-1:0] cnt;

  // Any sample matching the accepted level restarts the run of differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable    <= 1'b0;
      cnt       <= '0;
      key_press <= 1'b0;
    end else begin
      key_press <= 1'b0;
      if (key_raw == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable    <= key_raw;
        cnt       <= '0;
        key_press <= key_raw;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_setter.sv
// Three-button editor for the clock core: snapshots and edits the running
// time, edits the alarm time/enable, and drives a blink mask for the cursor.
module time_setter
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BLINK_CYCLES    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_mode,
  input  logic                 key_sel,
  input  logic                 key_inc,
  time_setter_if.master        bus,
  output logic [5:0]           blink_mask,
  output logic [1:0]           edit_mode
);

  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic          mode_press, sel_press, inc_press;
  edit_state_t   state;
  logic [2:0]    cursor;
  logic [3:0]    set_d   [6];
  logic [3:0]    alarm_d [2:5];
  logic          set_time_finish_r, clock_en_r;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [2:0]    alarm_idx;
  logic [3:0]    set_next, alarm_next;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
    .clk(clk), .rst_n(rst_n), .key_raw(key_mode), .key_press(mode_press));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sel (
    .clk(clk), .rst_n(rst_n), .key_raw(key_sel), .key_press(sel_press));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
    .clk(clk), .rst_n(rst_n), .key_raw(key_inc), .key_press(inc_press));

  // The alarm has no seconds, so the cursor never rests below min_ge there.
  always_comb begin
    alarm_idx  = (cursor < IDX_MIN_GE) ? IDX_MIN_GE : cursor;
    set_next   = bcd_inc(set_d[cursor], digit_limit(cursor, set_d[IDX_HOUR_SHI]));
    alarm_next = bcd_inc(alarm_d[alarm_idx], digit_limit(alarm_idx, alarm_d[IDX_HOUR_SHI]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= RUN;
      set_time_finish_r <= 1'b1;
      cursor            <= IDX_HOUR_SHI;
      clock_en_r        <= 1'b0;
      blink_cnt         <= '0;
      blink_phase       <= 1'b0;
      for (int i = 0; i < 6; i++) set_d[i] <= '0;
      for (int i = 2; i < 6; i++) alarm_d[i] <= '0;
    end else begin
      if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      // Mode and cursor moves restart the blink so the new digit shows first.
      if (mode_press) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
        cursor      <= IDX_HOUR_SHI;
        case (state)
          RUN: begin
            state                <= EDIT_TIME;
            set_time_finish_r    <= 1'b0;
            set_d[IDX_SEC_GE]    <= bus.cur_sec_ge;
            set_d[IDX_SEC_SHI]   <= bus.cur_sec_shi;
            set_d[IDX_MIN_GE]    <= bus.cur_min_ge;
            set_d[IDX_MIN_SHI]   <= bus.cur_min_shi;
            set_d[IDX_HOUR_GE]   <= bus.cur_hour_ge;
            set_d[IDX_HOUR_SHI]  <= bus.cur_hour_shi;
          end
          EDIT_TIME: begin
            state             <= EDIT_ALARM;
            set_time_finish_r <= 1'b1;
          end
          default: state <= RUN;
        endcase
      end else if (sel_press && state != RUN) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
        if (state == EDIT_TIME)
          cursor <= (cursor == IDX_SEC_GE) ? IDX_HOUR_SHI : cursor - 3'd1;
        else
          cursor <= (cursor <= IDX_MIN_GE) ? IDX_HOUR_SHI : cursor - 3'd1;
      end else if (inc_press) begin
        case (state)
          RUN: clock_en_r <= ~clock_en_r;
          EDIT_TIME: begin
            set_d[cursor] <= set_next;
            if (cursor == IDX_HOUR_SHI && set_next == LIM_HOUR_SHI &&
                set_d[IDX_HOUR_GE] > LIM_HOUR_GE_HI)
              set_d[IDX_HOUR_GE] <= LIM_HOUR_GE_HI;
          end
          default: begin
            alarm_d[alarm_idx] <= alarm_next;
            if (alarm_idx == IDX_HOUR_SHI && alarm_next == LIM_HOUR_SHI &&
                alarm_d[IDX_HOUR_GE] > LIM_HOUR_GE_HI)
              alarm_d[IDX_HOUR_GE] <= LIM_HOUR_GE_HI;
          end
        endcase
      end
    end
  end

  always_comb begin
    blink_mask = '0;
    if (state != RUN) blink_mask[cursor] = blink_phase;
  end

  assign edit_mode           = state;
  assign bus.set_time_finish = set_time_finish_r;
  assign bus.set_sec_ge      = set_d[IDX_SEC_GE];
  assign bus.set_sec_shi     = set_d[IDX_SEC_SHI];
  assign bus.set_min_ge      = set_d[IDX_MIN_GE];
  assign bus.set_min_shi     = set_d[IDX_MIN_SHI];
  assign bus.set_hour_ge     = set_d[IDX_HOUR_GE];
  assign bus.set_hour_shi    = set_d[IDX_HOUR_SHI];
  assign bus.clock_en        = clock_en_r;
  assign bus.clock_min_ge    = alarm_d[IDX_MIN_GE];
  assign bus.clock_min_shi   = alarm_d[IDX_MIN_SHI];
  assign bus.clock_hour_ge   = alarm_d[IDX_HOUR_GE];
  assign bus.clock_hour_shi  = alarm_d[IDX_HOUR_SHI];

endmodule

// File: tb/tb_time_setter.sv
// Directed bench for time_setter: expected values queued as each step is
// driven, then popped and compared against the outputs.
module tb_time_setter;

  localparam logic [2:0] K_MODE = 3'b100;
  localparam logic [2:0] K_SEL  = 3'b010;
  localparam logic [2:0] K_INC  = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_mode = 1'b0, key_sel = 1'b0, key_inc = 1'b0;
  logic [5:0] blink_mask;
  logic [1:0] edit_mode;

  int          compared = 0;
  int          mismatched = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  time_setter_if bus();

  time_setter #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .key_mode(key_mode), .key_sel(key_sel), .key_inc(key_inc),
    .bus(bus), .blink_mask(blink_mask), .edit_mode(edit_mode));

  always #5 clk = ~clk;

  function automatic logic [31:0] setTime();
    return {8'h0, bus.set_hour_shi, bus.set_hour_ge, bus.set_min_shi, bus.set_min_ge,
            bus.set_sec_shi, bus.set_sec_ge};
  endfunction

  function automatic logic [31:0] alarmTime();
    return {16'h0, bus.clock_hour_shi, bus.clock_hour_ge, bus.clock_min_shi, bus.clock_min_ge};
  endfunction

  task automatic expectVal(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic checkOutput(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_empty: observed %0h, nothing expected", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        mismatched++;
        $error("[TB] FAIL %s: observed %0h required %0h", t, obs, e);
      end
    end
  endtask

  task automatic setCur(input logic [23:0] t);
    {bus.cur_hour_shi, bus.cur_hour_ge, bus.cur_min_shi, bus.cur_min_ge,
     bus.cur_sec_shi, bus.cur_sec_ge} = t;
  endtask

  // Holds the keys long enough to act, releases, then waits 8 cycles past the action.
  task automatic applyStimulus(input logic [2:0] keys);
    @(negedge clk);
    {key_mode, key_sel, key_inc} = keys;
    repeat (5) @(negedge clk);
    {key_mode, key_sel, key_inc} = 3'b000;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    setCur(24'h123456);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    expectVal("rst_finish", 1);
    expectVal("rst_mode", 0);
    expectVal("rst_set", 0);
    expectVal("rst_blink", 0);
    expectVal("rst_clock_en", 0);
    expectVal("rst_alarm", 0);
    checkOutput(32'(bus.set_time_finish));
    checkOutput(32'(edit_mode));
    checkOutput(setTime());
    checkOutput(32'(blink_mask));
    checkOutput(32'(bus.clock_en));
    checkOutput(alarmTime());

    expectVal("enter_mode", 1);
    expectVal("enter_finish", 0);
    expectVal("enter_snapshot", 32'h123456);
    expectVal("enter_blink0", 0);
    @(negedge clk);
    key_mode = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput(32'(edit_mode));
    checkOutput(32'(bus.set_time_finish));
    checkOutput(setTime());
    checkOutput(32'(blink_mask));
    setCur(24'h999999);
    expectVal("blink_on", 32'h20);
    expectVal("snapshot_hold", 32'h123456);
    repeat (8) @(negedge clk);
    checkOutput(32'(blink_mask));
    checkOutput(setTime());
    expectVal("blink_off", 0);
    repeat (8) @(negedge clk);
    checkOutput(32'(blink_mask));
    key_mode = 1'b0;
    repeat (6) @(negedge clk);

    expectVal("inc_hs_22", 32'h223456);
    applyStimulus(K_INC);
    checkOutput(setTime());
    expectVal("inc_hs_02", 32'h023456);
    applyStimulus(K_INC);
    checkOutput(setTime());
    expectVal("inc_hs_12", 32'h123456);
    applyStimulus(K_INC);
    checkOutput(setTime());
    expectVal("sel_cur4", 32'h10);
    applyStimulus(K_SEL);
    checkOutput(32'(blink_mask));
    for (int i = 0; i < 6; i++) applyStimulus(K_INC);
    expectVal("inc_hg_18", 32'h183456);
    checkOutput(setTime());
    expectVal("sel_cur3", 32'h08);
    expectVal("sel_cur2", 32'h04);
    expectVal("sel_cur1", 32'h02);
    expectVal("sel_cur0", 32'h01);
    expectVal("sel_wrap5", 32'h20);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(K_SEL);
      checkOutput(32'(blink_mask));
    end
    expectVal("clamp_23", 32'h233456);
    applyStimulus(K_INC);
    checkOutput(setTime());
    applyStimulus(K_SEL);
    expectVal("hg_wrap_3_0", 32'h203456);
    applyStimulus(K_INC);
    checkOutput(setTime());
    for (int i = 0; i < 3; i++) applyStimulus(K_SEL);
    expectVal("sec_shi_no_carry", 32'h203406);
    applyStimulus(K_INC);
    checkOutput(setTime());

    expectVal("alarm_mode", 2);
    expectVal("alarm_finish", 1);
    expectVal("alarm_set_hold", 32'h203406);
    expectVal("alarm_blink", 32'h20);
    applyStimulus(K_MODE);
    checkOutput(32'(edit_mode));
    checkOutput(32'(bus.set_time_finish));
    checkOutput(setTime());
    checkOutput(32'(blink_mask));
    applyStimulus(K_SEL);
    for (int i = 0; i < 7; i++) applyStimulus(K_INC);
    applyStimulus(K_SEL);
    for (int i = 0; i < 3; i++) applyStimulus(K_INC);
    expectVal("alarm_0730", 32'h0730);
    checkOutput(alarmTime());
    expectVal("alarm_sel2", 32'h04);
    applyStimulus(K_SEL);
    checkOutput(32'(blink_mask));
    expectVal("alarm_wrap5", 32'h20);
    applyStimulus(K_SEL);
    checkOutput(32'(blink_mask));

    expectVal("run_mode", 0);
    expectVal("run_blink", 0);
    applyStimulus(K_MODE);
    checkOutput(32'(edit_mode));
    checkOutput(32'(blink_mask));
    expectVal("en_on", 1);
    applyStimulus(K_INC);
    checkOutput(32'(bus.clock_en));
    expectVal("en_off", 0);
    expectVal("alarm_kept", 32'h0730);
    applyStimulus(K_INC);
    checkOutput(32'(bus.clock_en));
    checkOutput(alarmTime());
    expectVal("run_sel_ignored", 0);
    applyStimulus(K_SEL);
    checkOutput(32'(edit_mode));

    expectVal("bounce_no_event", 0);
    foreach (exp_q[i]) ;
    begin
      logic [6:0] pat;
      pat = 7'b1100110;
      for (int i = 6; i >= 0; i--) begin
        @(negedge clk);
        key_mode = pat[i];
      end
    end
    repeat (10) @(negedge clk);
    checkOutput(32'(edit_mode));

    setCur(24'h235959);
    expectVal("same_cycle_mode", 1);
    expectVal("same_cycle_en", 0);
    expectVal("same_cycle_snap", 32'h235959);
    expectVal("same_cycle_blink", 32'h20);
    applyStimulus(K_MODE | K_INC);
    checkOutput(32'(edit_mode));
    checkOutput(32'(bus.clock_en));
    checkOutput(setTime());
    checkOutput(32'(blink_mask));
    expectVal("hs_wrap_2_0", 32'h035959);
    applyStimulus(K_INC);
    checkOutput(setTime());

    expectVal("arst_mode", 0);
    expectVal("arst_finish", 1);
    expectVal("arst_set", 0);
    expectVal("arst_alarm", 0);
    expectVal("arst_blink", 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput(32'(edit_mode));
    checkOutput(32'(bus.set_time_finish));
    checkOutput(setTime());
    checkOutput(alarmTime());
    checkOutput(32'(blink_mask));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/time_setter.md
Name: time_setter

Overview:
Button-driven editor that writes the time-set and alarm-set interface of the clock core: set_time_finish, set_* digits, clock_en and clock_* digits.
- Takes three raw push-buttons and the core's current BCD time digits.
- Sits between the board buttons and the time-keeping core; also drives a blink mask to the display scanner.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable clk cycles required before a button level is accepted
BLINK_CYCLES, 8, clk cycles per blink phase (toggle period)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
key_mode  in  1  raw button, active-high: cycle RUN/EDIT_TIME/EDIT_ALARM
key_sel  in  1  raw button: move cursor
key_inc  in  1  raw button: increment selected digit; in RUN, toggle alarm enable
cur_sec_ge, cur_sec_shi, cur_min_ge, cur_min_shi, cur_hour_ge, cur_hour_shi  in  4 each  current time from the core
set_time_finish  out  1  0 = core loads set_* every cycle; 1 = core runs
set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi  out  4 each  edited time
clock_en  out  1  alarm enable
clock_min_ge, clock_min_shi, clock_hour_ge, clock_hour_shi  out  4 each  alarm time
blink_mask  out  6  per-digit blank request; bit5=hour_shi … bit0=sec_ge
edit_mode  out  2  0=RUN, 1=EDIT_TIME, 2=EDIT_ALARM

Behaviour:
- Reset values:
  - state RUN; set_time_finish=1.
  - All set_* and clock_* digits = 0; clock_en=0.
  - cursor=5; blink_mask=0; edit_mode=0; blink counter=0.
- Debounce, per key:
  - A level is accepted after DEBOUNCE_CYCLES consecutive equal samples.
  - A press event is a 1-cycle pulse on the accepted 0->1 transition.
  - Press-to-action latency is DEBOUNCE_CYCLES+1 clk from the raw edge. No event on release.
- Same-cycle events: priority mode > sel > inc; the losing events are dropped, not queued.
- mode press transitions:
  - RUN -> EDIT_TIME:
    - On the same edge, set_* <= cur_* (snapshot), set_time_finish <= 0, cursor <= 5.
  - EDIT_TIME -> EDIT_ALARM:
    - set_time_finish <= 1 on the same edge; the core resumes from the edited value.
    - cursor <= 5, where alarm index 5=hour_shi, 4=hour_ge, 3=min_shi, 2=min_ge.
  - EDIT_ALARM -> RUN: cursor <= 5.
- sel press:
  - EDIT_TIME: cursor decrements 5,4,3,2,1,0 then wraps to 5.
  - EDIT_ALARM: cursor decrements 5..2 then wraps to 5.
  - RUN: ignored.
- inc press: increment the digit at cursor, wrapping to 0 at its limit.
  - Limits: sec_ge/min_ge 9; sec_shi/min_shi 5; hour_shi 2.
  - hour_ge limit is 9, or 3 when hour_shi==2.
  - When hour_shi becomes 2 while hour_ge>3, hour_ge <= 3 on the same edge. Applies identically to the alarm hour digits.
  - In RUN, inc toggles clock_en; alarm digits are unchanged.
- While set_time_finish=0, set_* holds between presses (the core reloads it every cycle).
- Blink:
  - A free-running counter toggles phase every BLINK_CYCLES.
  - In edit states, blink_mask has only bit[cursor] set, equal to phase; in RUN it is 0.
  - The counter restarts at 0 (phase 0) on every mode or sel action, so the new digit is visible first.
- Reset mid-edit: immediate return to RUN with set_time_finish=1; the snapshot is lost.
- Digits are stored 4-bit BCD; arithmetic never produces values above the limits.

Decomposition:
- Shared package clock_pkg:
  - State encodings RUN/EDIT_TIME/EDIT_ALARM.
  - Digit index constants IDX_HOUR_SHI=5 … IDX_SEC_GE=0.
  - Digit limit constants (9, 5, 2, 3).
- One sub-module, key_debounce: parameter DEBOUNCE_CYCLES; ports clk, rst_n, key_raw, key_press. Instantiated three times.

Test Plan:
- Reset, then cur=12:34:56 with no keys -> set_time_finish=1, edit_mode=0, all set_*=0, blink_mask=0.
- mode pulse held 6 cycles (cur=12:34:56) -> 5 clk after the raw edge: edit_mode=1, set_time_finish=0, set_*=1,2,3,4,5,6, blink_mask toggles bit5 every 8 cycles.
- In EDIT_TIME at 12:34:56, inc on hour_shi -> 22:34:56; a second inc -> 02:34:56. At 18:xx, inc hour_shi -> 28 clamped to 23; hour_ge then wraps 3->0.
- sel pressed 6 times in EDIT_TIME -> cursor 4,3,2,1,0,5; inc at cursor 1 with sec_shi=5 -> 0, no carry into min_ge.
- mode then mode again after edits -> EDIT_ALARM with set_time_finish=1; edit alarm to 07:30; mode to RUN; inc -> clock_en=1; inc again -> clock_en=0; clock_* stays 07:30.
- Raw key bouncing 1-0-1 at 2-cycle spacing -> no event. mode and inc accepted in the same cycle -> only the mode transition occurs. rst_n low mid-edit -> all outputs at reset values asynchronously.
